// File: rtl/player_ctrl.sv
// player_ctrl: per-player sprite position/facing/animation FSM (IDLE, WALK, AIR; CROUCH when `PLAYER_CROUCH_EN is defined).
// State moves one Clk after a sampled frame_clk rising edge; is_player is combinational; no backpressure, keys are level-sampled.
module player_ctrl #(
  parameter int         X_START     = 280,
  parameter int         X_MIN       = 0,
  parameter int         X_MAX       = 639,
  parameter int         Y_MIN       = 1,
  parameter int         Y_FLOOR     = 479,
  parameter int         WIDTH       = 60,
  parameter int         HEIGHT      = 73,
  parameter int         STEP        = 5,
  parameter int         WALK_FRAMES = 9,
  parameter int         FRAME_DIV   = 3,
  parameter int         JUMP_V      = 12,
  parameter int         GRAVITY     = 1,
  parameter logic [7:0] KEY_LEFT    = 8'h1C,
  parameter logic [7:0] KEY_RIGHT   = 8'h23,
  parameter logic [7:0] KEY_JUMP    = 8'h1D
`ifdef PLAYER_CROUCH_EN
  ,
  parameter logic [7:0] KEY_CROUCH  = 8'h16
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       press,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       direction,
  output logic [9:0] action,
  output logic       airborne,
  output logic       is_player
);

  localparam logic [9:0]         GROUND_Y   = 10'(Y_FLOOR - HEIGHT);
  localparam logic [9:0]         A_LAST     = 10'(WALK_FRAMES - 1);
  localparam logic [9:0]         A_IDLE     = 10'(WALK_FRAMES);
  localparam logic [9:0]         A_JUMP     = 10'(WALK_FRAMES + 1);
  localparam logic [10:0]        X_LO       = 11'(X_MIN);
  localparam logic [10:0]        X_HI       = 11'(X_MAX - WIDTH);
  localparam logic [10:0]        STEP_W     = 11'(STEP);
  localparam logic [7:0]         DIV_LAST   = 8'(FRAME_DIV - 1);
  localparam logic signed [9:0]  VY_TAKEOFF = 10'(-JUMP_V);
  localparam logic signed [9:0]  VY_GRAV    = 10'(GRAVITY);
  localparam logic signed [11:0] Y_GROUND_S = 12'(Y_FLOOR - HEIGHT);
  localparam logic signed [11:0] Y_CEIL_S   = 12'(Y_MIN);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_AIR, S_CROUCH} state_t;

  state_t             state, state_n;
  logic               frame_s1, frame_s2, tick;
  logic signed [9:0]  vy, vy_n, vy_use;
  logic [7:0]         div_cnt, cnt_n;
  logic               jump_armed, armed_n;
  logic [9:0]         x_n, y_n, act_n, x_step;
  logic               dir_n, air_upd;
  logic               key_l, key_r, key_j;
  logic [10:0]        x_right, x_hi_box, y_lo_box, y_hi_box;
  logic signed [11:0] y_sum;

  assign tick  = frame_s1 && !frame_s2;
  assign key_l = press && (keycode == KEY_LEFT);
  assign key_r = press && (keycode == KEY_RIGHT);
  assign key_j = press && (keycode == KEY_JUMP);
`ifdef PLAYER_CROUCH_EN
  logic key_c;
  assign key_c = press && (keycode == KEY_CROUCH);
`endif

  // Horizontal step toward the pressed side, clamped exactly to the wall.
  assign x_right = {1'b0, pos_x} + STEP_W;
  always_comb begin
    x_step = pos_x;
    if (key_r)
      x_step = (x_right > X_HI) ? X_HI[9:0] : x_right[9:0];
    else if ({1'b0, pos_x} < X_LO + STEP_W)
      x_step = X_LO[9:0];
    else
      x_step = pos_x - STEP_W[9:0];
  end

  assign vy_use = (state == S_AIR) ? vy : VY_TAKEOFF;
  assign y_sum  = $signed({2'b00, pos_y}) + $signed({{2{vy_use[9]}}, vy_use});

  always_comb begin
    state_n = state;
    x_n     = pos_x;
    y_n     = pos_y;
    vy_n    = vy;
    dir_n   = direction;
    act_n   = action;
    cnt_n   = div_cnt;
    armed_n = jump_armed;
    air_upd = 1'b0;
    if (tick) begin
      if (!key_j) armed_n = 1'b1;
      case (state)
        S_AIR: begin
          air_upd = 1'b1;
          if (key_l || key_r) begin
            dir_n = key_r;
            x_n   = x_step;
          end
        end
`ifdef PLAYER_CROUCH_EN
        S_CROUCH: begin
          if (!key_c) begin
            state_n = S_IDLE;
            act_n   = A_IDLE;
            cnt_n   = 8'd0;
          end
        end
`endif
        default: begin
`ifdef PLAYER_CROUCH_EN
          if (key_c) begin
            state_n = S_CROUCH;
            act_n   = 10'(WALK_FRAMES + 2);
            cnt_n   = 8'd0;
          end else
`endif
          if (key_j && jump_armed) begin
            state_n = S_AIR;
            act_n   = A_JUMP;
            cnt_n   = 8'd0;
            armed_n = 1'b0;
            air_upd = 1'b1;
          end else if (key_l || key_r) begin
            state_n = S_WALK;
            dir_n   = key_r;
            x_n     = x_step;
            if (state != S_WALK || direction != key_r) begin
              act_n = 10'd0;
              cnt_n = 8'd0;
            end else if (div_cnt == DIV_LAST) begin
              act_n = (action == A_LAST) ? 10'd0 : action + 10'd1;
              cnt_n = 8'd0;
            end else begin
              cnt_n = div_cnt + 8'd1;
            end
          end else begin
            state_n = S_IDLE;
            act_n   = A_IDLE;
            cnt_n   = 8'd0;
          end
        end
      endcase
      // Takeoff applies its first velocity step on the same tick.
      if (air_upd) begin
        if (y_sum >= Y_GROUND_S) begin
          y_n     = GROUND_Y;
          vy_n    = 10'sd0;
          state_n = S_IDLE;
          act_n   = A_IDLE;
        end else if (y_sum < Y_CEIL_S) begin
          y_n  = Y_CEIL_S[9:0];
          vy_n = 10'sd0;
        end else begin
          y_n  = y_sum[9:0];
          vy_n = vy_use + VY_GRAV;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_s1   <= 1'b0;
      frame_s2   <= 1'b0;
      state      <= S_IDLE;
      pos_x      <= 10'(X_START);
      pos_y      <= GROUND_Y;
      direction  <= 1'b1;
      action     <= A_IDLE;
      vy         <= 10'sd0;
      div_cnt    <= 8'd0;
      jump_armed <= 1'b1;
    end else begin
      frame_s1   <= frame_clk;
      frame_s2   <= frame_s1;
      state      <= state_n;
      pos_x      <= x_n;
      pos_y      <= y_n;
      direction  <= dir_n;
      action     <= act_n;
      vy         <= vy_n;
      div_cnt    <= cnt_n;
      jump_armed <= armed_n;
    end
  end

  assign airborne = (state == S_AIR);

  assign x_hi_box = {1'b0, pos_x} + 11'(WIDTH - 1);
  assign y_hi_box = {1'b0, pos_y} + 11'(HEIGHT - 1);
`ifdef PLAYER_CROUCH_EN
  assign y_lo_box = {1'b0, pos_y} + ((state == S_CROUCH) ? 11'(HEIGHT / 2) : 11'd0);
`else
  assign y_lo_box = {1'b0, pos_y};
`endif
  assign is_player = ({1'b0, DrawX} >= {1'b0, pos_x}) && ({1'b0, DrawX} <= x_hi_box) &&
                     ({1'b0, DrawY} >= y_lo_box) && ({1'b0, DrawY} <= y_hi_box);

endmodule

// File: tb/tb_player_ctrl.sv
// Directed self-checking bench for player_ctrl: walk cycle, walls, jump arc, hitbox, reset, crouch.
module tb_player_ctrl;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       press = 1'b0;
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic [9:0] pos_x, pos_y, action;
  logic       direction, airborne, is_player;

  int tests = 0;
  int fails = 0;

  localparam logic [7:0] K_L = 8'h1C;
  localparam logic [7:0] K_R = 8'h23;
  localparam logic [7:0] K_J = 8'h1D;
  localparam logic [7:0] K_C = 8'h16;

  player_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .press(press),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y), .direction(direction),
    .action(action), .airborne(airborne), .is_player(is_player)
  );

  always #5 Clk = ~Clk;

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic set_key(input logic [7:0] k, input logic p);
    @(negedge Clk);
    keycode = k;
    press   = p;
  endtask

  task automatic do_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (pos_x !== 10'd280) begin fails++; $display("FAIL reset_x got %0d want 280", pos_x); end
    tests++; if (pos_y !== 10'd406) begin fails++; $display("FAIL reset_y got %0d want 406", pos_y); end
    tests++; if (action !== 10'd9) begin fails++; $display("FAIL reset_action got %0d want 9", action); end
    tests++; if (direction !== 1'b1) begin fails++; $display("FAIL reset_dir got %0b want 1", direction); end
    tests++; if (airborne !== 1'b0) begin fails++; $display("FAIL reset_air got %0b want 0", airborne); end
    set_key(K_R, 1'b1);
    repeat (12) @(negedge Clk);
    tests++; if (pos_x !== 10'd280) begin fails++; $display("FAIL no_tick_hold got %0d want 280", pos_x); end
    set_key(8'h00, 1'b0);
  endtask

  task automatic test_walk_right();
    int exp_a;
    do_reset();
    set_key(K_R, 1'b1);
    for (int t = 1; t <= 30; t++) begin
      do_tick();
      exp_a = ((t - 1) / 3) % 9;
      tests++; if (action !== 10'(exp_a)) begin fails++; $display("FAIL walk_r_action tick %0d got %0d want %0d", t, action, exp_a); end
      tests++; if (pos_x !== 10'(280 + 5 * t)) begin fails++; $display("FAIL walk_r_x tick %0d got %0d want %0d", t, pos_x, 280 + 5 * t); end
    end
    tests++; if (direction !== 1'b1) begin fails++; $display("FAIL walk_r_dir got %0b want 1", direction); end
    set_key(8'h00, 1'b0);
  endtask

  task automatic test_walk_left_wall();
    int exp_x;
    do_reset();
    set_key(K_L, 1'b1);
    for (int t = 1; t <= 60; t++) begin
      do_tick();
      exp_x = (t <= 56) ? 280 - 5 * t : 0;
      tests++; if (pos_x !== 10'(exp_x)) begin fails++; $display("FAIL walk_l_x tick %0d got %0d want %0d", t, pos_x, exp_x); end
    end
    tests++; if (direction !== 1'b0) begin fails++; $display("FAIL walk_l_dir got %0b want 0", direction); end
    tests++; if (action !== 10'd1) begin fails++; $display("FAIL walk_l_wall_anim got %0d want 1", action); end
    set_key(8'h00, 1'b0);
    do_tick();
    tests++; if (action !== 10'd9) begin fails++; $display("FAIL release_action got %0d want 9", action); end
    tests++; if (direction !== 1'b0) begin fails++; $display("FAIL release_dir got %0b want 0", direction); end
    tests++; if (pos_x !== 10'd0) begin fails++; $display("FAIL release_x got %0d want 0", pos_x); end
  endtask

  task automatic test_reverse();
    do_reset();
    set_key(K_R, 1'b1);
    repeat (5) do_tick();
    tests++; if (action !== 10'd1) begin fails++; $display("FAIL rev_pre_action got %0d want 1", action); end
    set_key(K_L, 1'b1);
    do_tick();
    tests++; if (action !== 10'd0) begin fails++; $display("FAIL rev_action got %0d want 0", action); end
    tests++; if (pos_x !== 10'd300) begin fails++; $display("FAIL rev_x got %0d want 300", pos_x); end
    tests++; if (direction !== 1'b0) begin fails++; $display("FAIL rev_dir got %0b want 0", direction); end
    set_key(8'h00, 1'b0);
  endtask

  task automatic test_jump();
    int jy [25] = '{394, 383, 373, 364, 356, 349, 343, 338, 334, 331, 329, 328, 328,
                    329, 331, 334, 338, 343, 349, 356, 364, 373, 383, 394, 406};
    do_reset();
    set_key(K_J, 1'b1);
    for (int t = 1; t <= 25; t++) begin
      do_tick();
      tests++; if (pos_y !== 10'(jy[t-1])) begin fails++; $display("FAIL jump_y tick %0d got %0d want %0d", t, pos_y, jy[t-1]); end
      tests++; if (action !== ((t < 25) ? 10'd10 : 10'd9)) begin fails++; $display("FAIL jump_action tick %0d got %0d", t, action); end
      tests++; if (airborne !== (t < 25)) begin fails++; $display("FAIL jump_air tick %0d got %0b", t, airborne); end
    end
    tests++; if (pos_x !== 10'd280) begin fails++; $display("FAIL jump_x got %0d want 280", pos_x); end
    repeat (2) do_tick();
    tests++; if (airborne !== 1'b0) begin fails++; $display("FAIL held_rejump_air got %0b want 0", airborne); end
    tests++; if (pos_y !== 10'd406) begin fails++; $display("FAIL held_rejump_y got %0d want 406", pos_y); end
    set_key(8'h00, 1'b0);
    do_tick();
    set_key(K_J, 1'b1);
    do_tick();
    tests++; if (pos_y !== 10'd394) begin fails++; $display("FAIL rejump_y got %0d want 394", pos_y); end
    tests++; if (airborne !== 1'b1) begin fails++; $display("FAIL rejump_air got %0b want 1", airborne); end
    set_key(8'h00, 1'b0);
  endtask

  task automatic test_right_wall_hitbox();
    do_reset();
    set_key(K_R, 1'b1);
    repeat (59) do_tick();
    tests++; if (pos_x !== 10'd575) begin fails++; $display("FAIL wall_r_pre got %0d want 575", pos_x); end
    do_tick();
    tests++; if (pos_x !== 10'd579) begin fails++; $display("FAIL wall_r_clamp got %0d want 579", pos_x); end
    tests++; if (action !== 10'd1) begin fails++; $display("FAIL wall_r_anim60 got %0d want 1", action); end
    do_tick();
    tests++; if (pos_x !== 10'd579) begin fails++; $display("FAIL wall_r_hold got %0d want 579", pos_x); end
    tests++; if (action !== 10'd2) begin fails++; $display("FAIL wall_r_anim61 got %0d want 2", action); end
    set_key(8'h00, 1'b0);
    DrawX = 10'd579; DrawY = 10'd406; #1;
    tests++; if (is_player !== 1'b1) begin fails++; $display("FAIL hit_tl got %0b want 1", is_player); end
    DrawX = 10'd638; DrawY = 10'd478; #1;
    tests++; if (is_player !== 1'b1) begin fails++; $display("FAIL hit_br got %0b want 1", is_player); end
    DrawX = 10'd639; DrawY = 10'd406; #1;
    tests++; if (is_player !== 1'b0) begin fails++; $display("FAIL hit_right_out got %0b want 0", is_player); end
    DrawX = 10'd578; DrawY = 10'd450; #1;
    tests++; if (is_player !== 1'b0) begin fails++; $display("FAIL hit_left_out got %0b want 0", is_player); end
    DrawX = 10'd600; DrawY = 10'd479; #1;
    tests++; if (is_player !== 1'b0) begin fails++; $display("FAIL hit_below got %0b want 0", is_player); end
    DrawX = 10'd600; DrawY = 10'd405; #1;
    tests++; if (is_player !== 1'b0) begin fails++; $display("FAIL hit_above got %0b want 0", is_player); end
  endtask

  task automatic test_reset_midjump();
    do_reset();
    set_key(K_L, 1'b1);
    do_tick();
    set_key(K_J, 1'b1);
    repeat (7) do_tick();
    tests++; if (pos_y !== 10'd343) begin fails++; $display("FAIL midjump_y got %0d want 343", pos_y); end
    tests++; if (direction !== 1'b0) begin fails++; $display("FAIL midjump_dir got %0b want 0", direction); end
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    tests++; if (pos_x !== 10'd280 || pos_y !== 10'd406) begin fails++; $display("FAIL midreset_pos got (%0d,%0d) want (280,406)", pos_x, pos_y); end
    tests++; if (action !== 10'd9) begin fails++; $display("FAIL midreset_action got %0d want 9", action); end
    tests++; if (airborne !== 1'b0) begin fails++; $display("FAIL midreset_air got %0b want 0", airborne); end
    tests++; if (direction !== 1'b1) begin fails++; $display("FAIL midreset_dir got %0b want 1", direction); end
    set_key(8'h00, 1'b0);
  endtask

  task automatic test_crouch();
    do_reset();
    set_key(K_C, 1'b1);
    repeat (3) do_tick();
    DrawX = 10'd300; DrawY = 10'd406; #1;
`ifdef PLAYER_CROUCH_EN
    tests++; if (action !== 10'd11) begin fails++; $display("FAIL crouch_action got %0d want 11", action); end
    tests++; if (pos_x !== 10'd280) begin fails++; $display("FAIL crouch_x got %0d want 280", pos_x); end
    tests++; if (is_player !== 1'b0) begin fails++; $display("FAIL crouch_hit_top got %0b want 0", is_player); end
    DrawY = 10'd442; #1;
    tests++; if (is_player !== 1'b1) begin fails++; $display("FAIL crouch_hit_mid got %0b want 1", is_player); end
    set_key(8'h00, 1'b0);
    do_tick();
    tests++; if (action !== 10'd9) begin fails++; $display("FAIL crouch_release got %0d want 9", action); end
`else
    tests++; if (action !== 10'd9) begin fails++; $display("FAIL nocrouch_action got %0d want 9", action); end
    tests++; if (pos_x !== 10'd280) begin fails++; $display("FAIL nocrouch_x got %0d want 280", pos_x); end
    tests++; if (is_player !== 1'b1) begin fails++; $display("FAIL nocrouch_hit got %0b want 1", is_player); end
    set_key(8'h00, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_walk_right();
    test_walk_left_wall();
    test_reverse();
    test_jump();
    test_right_wall_hitbox();
    test_reset_midjump();
    test_crouch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
